// File: rtl/efpga_cfg_pkg.sv
// Shared definitions for the eFPGA configuration path: default sizes,
// the frame start marker and the loader FSM state encoding.
package efpga_cfg_pkg;

  // Width of the switch-block configuration word; always a multiple of 8.
  localparam int PROG_W_DEFAULT = 176;

  // Frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHK    = 2'd2,
    ST_COMMIT = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/config_loader.sv
// Byte-serial configuration loader. It hunts for a sync byte, shifts the
// payload into a shadow register, and checks an XOR checksum. Only a frame
// with a correct checksum is copied to the live configuration word, so the
// switch never sees a partial or corrupted frame.
module config_loader
  import efpga_cfg_pkg::*;
#(
  parameter int         PROG_W    = PROG_W_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_abort,
  output logic [PROG_W-1:0] prog,
  output logic              prog_valid,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              busy
);

  localparam int NB    = PROG_W / 8;
  localparam int CNT_W = $clog2(NB + 1);

  // Count value of the final payload byte; the counter never passes NB.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

  cfg_state_e        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [7:0]        xor_q,        xor_d;
  logic [PROG_W-1:0] shadow_q,     shadow_d;
  logic              match_q,      match_d;
  logic [PROG_W-1:0] prog_q,       prog_d;
  logic              prog_valid_q, prog_valid_d;
  logic              done_q,       done_d;
  logic              err_q,        err_d;
  logic              beat;

  // The loader holds off the bitstream only during the single commit cycle
  // and while reset is asserted.
  assign cfg_ready  = !rst && (state_q != ST_COMMIT);
  assign busy       = !rst && (state_q != ST_IDLE);
  assign beat       = cfg_valid && cfg_ready;

  assign prog       = prog_q;
  assign prog_valid = prog_valid_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;

  // Next-state, datapath and pulse logic for the frame FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    shadow_d     = shadow_q;
    match_d      = match_q;
    prog_d       = prog_q;
    prog_valid_d = prog_valid_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Anything other than the marker is dropped while hunting.
        if (!cfg_abort && beat && (cfg_data == SYNC_BYTE)) begin
          cnt_d   = '0;
          xor_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Abort wins over a data beat in the same cycle.
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          shadow_d = {shadow_q[PROG_W-9:0], cfg_data};
          xor_d    = xor_q ^ cfg_data;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_CHK;
          end
        end
      end

      ST_CHK: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          match_d = (cfg_data == xor_q);
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        // Abort is not looked at here: the decision is already made.
        if (match_q) begin
          prog_d       = shadow_q;
          prog_valid_d = 1'b1;
          done_d       = 1'b1;
        end else begin
          err_d        = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the live word and shadow are cleared too, because a reset must
    // leave the switch in a known unconfigured state, not just the FSM.
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      xor_q        <= '0;
      shadow_q     <= '0;
      match_q      <= 1'b0;
      prog_q       <= '0;
      prog_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values
      // from before this edge, whatever the statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      shadow_q     <= shadow_d;
      match_q      <= match_d;
      prog_q       <= prog_d;
      prog_valid_q <= prog_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader. Expected commit/error results are
// queued as each checksum byte is driven and retired when the loader pulses.
// A monitor also checks on every cycle that prog only moves at a good commit.
module tb_config_loader;
  import efpga_cfg_pkg::*;

  localparam int PW = PROG_W_DEFAULT;
  localparam int NB = PW / 8;

  typedef logic [PW-1:0] word_t;
  typedef struct {
    bit    is_ok;
    word_t prog;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_abort;
  word_t       prog;
  logic        prog_valid;
  logic        cfg_done;
  logic        cfg_err;
  logic        busy;

  config_loader #(
    .PROG_W   (PW),
    .SYNC_BYTE(SYNC_BYTE_DEFAULT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_abort (cfg_abort),
    .prog      (prog),
    .prog_valid(prog_valid),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb[$];
  word_t      exp_prog;
  logic       exp_pv;
  logic       prev_done;
  logic       prev_err;
  logic [7:0] pl [NB];
  bit         toggle_gap;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader accepts it.
  task automatic send_byte(input logic [7:0] b, input bit abort);
    int waited;
    if (toggle_gap) begin
      cfg_valid = 1'b0;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b1;
    cfg_data  = b;
    cfg_abort = abort;
    waited    = 0;
    @(negedge clk);
    while (!cfg_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!cfg_ready) check("ready_timeout", word_t'(0), word_t'(1));
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
  endtask

  // Send sync, the payload in pl[], then chk. Returns 1 time unit after
  // the edge that accepted the checksum byte.
  task automatic send_frame(input logic [7:0] chk);
    word_t      e;
    logic [7:0] x;
    e = '0;
    x = 8'h00;
    send_byte(SYNC_BYTE_DEFAULT, 1'b0);
    for (int i = 0; i < NB; i++) begin
      send_byte(pl[i], 1'b0);
      e[PW-1-8*i -: 8] = pl[i];
      x = x ^ pl[i];
    end
    sb.push_back('{is_ok: (x == chk), prog: e});
    send_byte(chk, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard retirement plus per-cycle hold and pulse-width checks.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      exp_prog  = '0;
      exp_pv    = 1'b0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      check("pulse_excl", word_t'(cfg_done & cfg_err), word_t'(0));
      if (cfg_done || cfg_err) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", word_t'({cfg_done, cfg_err}), word_t'(0));
        end else begin
          e = sb.pop_front();
          check("result_kind", word_t'(cfg_done), word_t'(e.is_ok));
          if (e.is_ok) begin
            exp_prog = e.prog;
            exp_pv   = 1'b1;
          end
        end
      end
      check("done_width", word_t'(cfg_done & prev_done), word_t'(0));
      check("err_width", word_t'(cfg_err & prev_err), word_t'(0));
      check("prog_hold", prog, exp_prog);
      check("prog_valid", word_t'(prog_valid), word_t'(exp_pv));
      prev_done = cfg_done;
      prev_err  = cfg_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_t lit;
    logic [7:0] x;

    rst        = 1'b1;
    cfg_data   = 8'h00;
    cfg_valid  = 1'b0;
    cfg_abort  = 1'b0;
    toggle_gap = 1'b0;

    // Reset state.
    idle(3);
    check("rst_prog", prog, word_t'(0));
    check("rst_prog_valid", word_t'(prog_valid), word_t'(0));
    check("rst_ready", word_t'(cfg_ready), word_t'(0));
    check("rst_busy", word_t'(busy), word_t'(0));
    check("rst_done", word_t'(cfg_done), word_t'(0));
    check("rst_err", word_t'(cfg_err), word_t'(0));
    rst = 1'b0;
    idle(1);
    check("idle_ready", word_t'(cfg_ready), word_t'(1));

    // Good frame FF FF 00 00 96 96 then zeros; exact latency.
    for (int i = 0; i < NB; i++) pl[i] = 8'h00;
    pl[0] = 8'hFF; pl[1] = 8'hFF; pl[4] = 8'h96; pl[5] = 8'h96;
    send_frame(8'h00);
    check("commit_ready", word_t'(cfg_ready), word_t'(0));
    check("commit_busy", word_t'(busy), word_t'(1));
    check("commit_done_early", word_t'(cfg_done), word_t'(0));
    check("commit_prog_early", prog, word_t'(0));
    idle(1);
    lit = {48'hFFFF00009696, 128'h0};
    check("f1_done", word_t'(cfg_done), word_t'(1));
    check("f1_prog", prog, lit);
    check("f1_prog_valid", word_t'(prog_valid), word_t'(1));
    check("f1_ready_after", word_t'(cfg_ready), word_t'(1));
    check("f1_busy_after", word_t'(busy), word_t'(0));
    idle(1);
    check("f1_done_off", word_t'(cfg_done), word_t'(0));

    // Bad checksum: error pulse, prog held.
    for (int i = 0; i < NB; i++) pl[i] = 8'h00;
    pl[0] = 8'h12;
    send_frame(8'h13);
    idle(1);
    check("f2_err", word_t'(cfg_err), word_t'(1));
    check("f2_done", word_t'(cfg_done), word_t'(0));
    check("f2_prog", prog, lit);
    idle(2);

    // Leading junk and a gap on every byte.
    toggle_gap = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h3C, 1'b0);
    for (int i = 0; i < NB; i++) pl[i] = 8'h01;
    send_frame(8'h00);
    toggle_gap = 1'b0;
    idle(3);
    check("f3_prog", prog, word_t'({NB{8'h01}}));

    // Abort together with the 10th payload byte, then a full frame.
    send_byte(SYNC_BYTE_DEFAULT, 1'b0);
    for (int i = 0; i < 9; i++) send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b1);
    check("abort_busy", word_t'(busy), word_t'(0));
    for (int i = 0; i < NB; i++) pl[i] = 8'h00;
    pl[0] = 8'h80;
    send_frame(8'h80);
    idle(3);
    check("f4_prog", prog, {8'h80, 168'h0});

    // Abort with the checksum byte in CHK: frame dropped, no pulse.
    send_byte(SYNC_BYTE_DEFAULT, 1'b0);
    for (int i = 0; i < NB; i++) send_byte(8'h11, 1'b0);
    check("chk_busy", word_t'(busy), word_t'(1));
    send_byte(8'h00, 1'b1);
    check("chk_abort_busy", word_t'(busy), word_t'(0));
    idle(3);

    // Payload containing the sync value; abort held during COMMIT.
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      pl[i] = (i % 5 == 2) ? SYNC_BYTE_DEFAULT : 8'($urandom_range(0, 255));
      x = x ^ pl[i];
    end
    send_frame(x);
    cfg_abort = 1'b1;
    check("f5_commit_ready", word_t'(cfg_ready), word_t'(0));
    idle(1);
    cfg_abort = 1'b0;
    check("f5_done", word_t'(cfg_done), word_t'(1));
    idle(2);

    // Reset after 5 payload bytes of a new frame, then a normal frame.
    send_byte(SYNC_BYTE_DEFAULT, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h77, 1'b0);
    rst = 1'b1;
    idle(1);
    check("mid_rst_prog", prog, word_t'(0));
    check("mid_rst_prog_valid", word_t'(prog_valid), word_t'(0));
    check("mid_rst_busy", word_t'(busy), word_t'(0));
    check("mid_rst_ready", word_t'(cfg_ready), word_t'(0));
    idle(1);
    rst = 1'b0;
    idle(1);
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      pl[i] = 8'($urandom_range(0, 255));
      x = x ^ pl[i];
    end
    send_frame(x);
    idle(1);
    check("f6_done", word_t'(cfg_done), word_t'(1));
    check("f6_prog_valid", word_t'(prog_valid), word_t'(1));

    idle(5);
    check("sb_empty", word_t'(sb.size()), word_t'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter PROG_W, default 176, width of the switch-block configuration word; SHALL be a multiple of 8.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 cfg_data  input  8  bitstream byte.
REQ-006 cfg_valid  input  1  cfg_data valid this cycle.
REQ-007 cfg_ready  output  1  loader accepts a byte this cycle; a beat transfers when cfg_valid && cfg_ready at a rising edge.
REQ-008 cfg_abort  input  1  discard the frame in progress.
REQ-009 prog  output  PROG_W  committed configuration word driven to the logic switch.
REQ-010 prog_valid  output  1  high once any frame has committed.
REQ-011 cfg_done  output  1  one-cycle pulse, frame committed.
REQ-012 cfg_err  output  1  one-cycle pulse, checksum mismatch, frame dropped.
REQ-013 busy  output  1  high when state is not IDLE.

Function
REQ-014 Frame SHALL be: SYNC_BYTE, then NB = PROG_W/8 payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
REQ-015 FSM states SHALL be IDLE, LOAD, CHK, COMMIT.
REQ-016 IDLE: cfg_ready=1; non-sync bytes are accepted and discarded; accepting SYNC_BYTE clears byte counter and running XOR and moves to LOAD.
REQ-017 LOAD: cfg_ready=1; each accepted byte shifts into shadow register as shadow <= {shadow[PROG_W-9:0], cfg_data} and XORs into running checksum; after the NB-th byte moves to CHK.
REQ-018 First payload byte SHALL end up in prog[PROG_W-1:PROG_W-8]; last payload byte in prog[7:0].
REQ-019 CHK: cfg_ready=1; accepted byte is compared with running XOR; result is registered and FSM moves to COMMIT.
REQ-020 COMMIT: cfg_ready=0 for exactly one cycle; on match prog <= shadow, prog_valid <= 1, cfg_done pulses; on mismatch prog unchanged, cfg_err pulses; FSM returns to IDLE.
REQ-021 Latency: checksum beat accepted at edge N; new prog and cfg_done/cfg_err visible after edge N+1, for one cycle only (pulses).
REQ-022 prog SHALL never change except at a successful commit; no partial frame ever reaches prog.
REQ-023 cfg_valid low in any state SHALL stall without state change; gaps of any length are allowed.
REQ-024 cfg_abort high in IDLE, LOAD or CHK SHALL return FSM to IDLE at the next edge, taking priority over a simultaneous data beat; prog, prog_valid unchanged; no pulse.
REQ-025 cfg_abort during COMMIT SHALL be ignored; the commit completes.
REQ-026 SYNC_BYTE value inside LOAD or CHK SHALL be treated as ordinary data.
REQ-027 Byte counter SHALL be sized $clog2(NB+1) bits and never wrap within a frame.

Reset
REQ-028 While rst is high at an edge: state IDLE, prog=0, prog_valid=0, cfg_done=0, cfg_err=0, shadow/counter/XOR=0; cfg_ready=0 and busy=0 while rst is high.
REQ-029 rst mid-frame SHALL discard the frame and clear prog to 0.

Structure
REQ-030 Shared package efpga_cfg_pkg SHALL hold PROG_W default, SYNC_BYTE, and the FSM state enum.
REQ-031 No sub-module; single module containing FSM, shadow shift register, counter and XOR accumulator.

Verification
REQ-032 Send A5, FF FF 00 00 96 96, 16x 00, checksum 00 -> after edge N+1 prog=176'hFFFF0000969600..00, cfg_done one cycle, prog_valid=1.
REQ-033 Send A5, 12, 21x 00, checksum 13 -> cfg_err one cycle, prog holds previous value, prog_valid unchanged.
REQ-034 Send 00 3C A5 then valid frame with payload 01 x22, checksum 00, cfg_valid toggling every other cycle -> leading bytes dropped, prog=22 bytes of 01, cfg_done once.
REQ-035 Assert cfg_abort with the 10th payload byte, then send a full valid frame (first byte 80, rest 00, checksum 80) -> no pulse from first frame; prog=176'h8000..00 after second.
REQ-036 Assert rst after 5 payload bytes following a committed frame -> prog=0, prog_valid=0, busy=0, cfg_ready=0 during rst; next valid frame commits normally.
REQ-037 Check cfg_ready=0 exactly in the COMMIT cycle and cfg_abort in COMMIT does not prevent cfg_done.
